noc_output_arbiter: RTL and testbench

NOC_OUTPUT_ARBITER -- requirements
Module: noc_output_arbiter

---
 rtl/noc_pkg.sv | 37 +++
 rtl/noc_output_arbiter_if.sv | 25 ++
 rtl/noc_rr_arbiter.sv | 28 ++
 rtl/noc_output_arbiter.sv | 151 +++++++++++++++
 tb/tb_noc_output_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC types: flit-type encoding, port naming and flit-type helpers.
package noc_pkg;

    localparam int unsigned NPORTS = 5;
    localparam int unsigned FLIT_W = 16;
    localparam int unsigned FT_W   = 2;

    typedef enum logic [FT_W-1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_NORTH = 3'd1,
        PORT_EAST  = 3'd2,
        PORT_SOUTH = 3'd3,
        PORT_WEST  = 3'd4
    } port_e;

    function automatic flit_type_t to_flit_type(input logic [FT_W-1:0] field);
        return flit_type_t'(field);
    endfunction

    // A flit that may start a packet when the output is free.
    function automatic logic opens_packet(input flit_type_t ft);
        return (ft == FT_HEAD) || (ft == FT_SINGLE);
    endfunction

    // A flit whose transfer ends the packet.
    function automatic logic closes_packet(input flit_type_t ft);
        return (ft == FT_TAIL) || (ft == FT_SINGLE);
    endfunction

endpackage

// File: rtl/noc_output_arbiter_if.sv
// Bus between the input-port FIFOs / output link and one output arbiter.
interface noc_output_arbiter_if #(
    parameter int unsigned NPORTS = noc_pkg::NPORTS,
    parameter int unsigned FLIT_W = noc_pkg::FLIT_W
);
    logic [NPORTS-1:0]        req_i;
    logic [NPORTS*FLIT_W-1:0] req_flit_i;
    logic [NPORTS-1:0]        shift_o;
    logic [FLIT_W-1:0]        out_flit_o;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [NPORTS-1:0]        grant_o;
    logic                     locked_o;
    logic                     timeout_o;

    modport master (
        input  req_i, req_flit_i, out_ready_i,
        output shift_o, out_flit_o, out_valid_o, grant_o, locked_o, timeout_o
    );

    modport slave (
        output req_i, req_flit_i, out_ready_i,
        input  shift_o, out_flit_o, out_valid_o, grant_o, locked_o, timeout_o
    );
endinterface

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin picker: first request at or above ptr_i, wrapping.
module noc_rr_arbiter #(
    parameter int unsigned N     = 5,
    parameter int unsigned PTR_W = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic             any_o
);
    import noc_pkg::*;

    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_o = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PTR_W'((32'(ptr_i) + k) % N);
            if ((grant_o == '0) && req_i[idx]) begin
                grant_o[idx] = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole output arbiter: round-robin packet lock on one output link.
// Optional starvation release enabled by macro NOC_ARB_TIMEOUT_EN.
module noc_output_arbiter #(
    parameter int unsigned NPORTS  = noc_pkg::NPORTS,
    parameter int unsigned FLIT_W  = noc_pkg::FLIT_W
`ifdef NOC_ARB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    noc_output_arbiter_if.master  bus
);
    import noc_pkg::*;

    localparam int unsigned PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [NPORTS-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;

    logic [NPORTS-1:0]  eligible, rr_grant;
    logic               rr_any;
    logic [PTR_W-1:0]   winner, next_ptr;
    logic [FLIT_W-1:0]  owner_flit;
    flit_type_t         owner_type;
    logic               owner_req, xfer;

    logic [NPORTS-1:0]  shift;
    logic [FLIT_W-1:0]  out_flit;
    logic               out_valid, timeout;

`ifdef NOC_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    // Only packet-opening flits may compete for an idle output.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            eligible[i] = bus.req_i[i] &
                opens_packet(to_flit_type(bus.req_flit_i[i*FLIT_W + FLIT_W - FT_W +: FT_W]));
        end
    end

    noc_rr_arbiter #(.N(NPORTS), .PTR_W(PTR_W)) u_rr (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant),
        .any_o   (rr_any)
    );

    always_comb begin
        winner     = '0;
        owner_flit = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (rr_grant[i]) winner = PTR_W'(i);
            if (owner_q == PTR_W'(i)) owner_flit = bus.req_flit_i[i*FLIT_W +: FLIT_W];
        end
    end

    assign owner_type = to_flit_type(owner_flit[FLIT_W-1 -: FT_W]);
    assign owner_req  = |(bus.req_i & grant_q);
    assign next_ptr   = (owner_q == PTR_W'(NPORTS - 1)) ? '0 : owner_q + PTR_W'(1);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        shift     = '0;
        out_flit  = '0;
        out_valid = 1'b0;
        timeout   = 1'b0;
        xfer      = 1'b0;
`ifdef NOC_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (rr_any && (eligible != '0)) begin
                    state_d = ST_LOCKED;
                    grant_d = rr_grant;
                    owner_d = winner;
`ifdef NOC_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_LOCKED: begin
                out_flit  = owner_flit;
                out_valid = owner_req;
                xfer      = owner_req & bus.out_ready_i;
                shift     = grant_q & {NPORTS{xfer}};
                if (xfer && closes_packet(owner_type)) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end
`ifdef NOC_ARB_TIMEOUT_EN
                // Only cycles where the owner has nothing to offer count toward starvation.
                if (xfer) begin
                    cnt_d = '0;
                end else if (!owner_req) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (cnt_q == CNT_W'(TIMEOUT)) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    cnt_d   = '0;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
`ifdef NOC_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
`ifdef NOC_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.shift_o     = shift;
    assign bus.out_flit_o  = out_flit;
    assign bus.out_valid_o = out_valid;
    assign bus.grant_o     = grant_q;
    assign bus.locked_o    = (state_q == ST_LOCKED);
    assign bus.timeout_o   = timeout;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: packet-level model plus directed scenarios.
module tb_noc_output_arbiter;
    import noc_pkg::*;

    localparam int unsigned NP  = 5;
    localparam int unsigned FW  = 16;
    localparam int          TMO = 16;
`ifdef NOC_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    noc_output_arbiter_if #(.NPORTS(NP), .FLIT_W(FW)) bus ();

    noc_output_arbiter #(
        .NPORTS(NP), .FLIT_W(FW)
`ifdef NOC_ARB_TIMEOUT_EN
        , .TIMEOUT(TMO)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Input-port FIFOs feeding the arbiter, plus stimulus controls.
    logic [FW-1:0] pq [NP][$];
    bit gap_en   = 1'b0;
    int rdy_mode = 1;     // 0 low, 1 high, 2 random
    int pushed   = 0;
    int xfers    = 0;

    // Reference model: owner port (-1 when free), rr pointer, starvation count.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    typedef struct packed {
        logic [NP-1:0] shift;
        logic [FW-1:0] flit;
        logic          valid;
        logic [NP-1:0] grant;
        logic          locked;
        logic          tmo;
    } exp_t;

    function automatic int ftype(input logic [FW-1:0] f);
        return int'(f[FW-1 -: 2]);
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        if (m_owner >= 0) begin
            e.flit   = bus.req_flit_i[m_owner*FW +: FW];
            e.valid  = bus.req_i[m_owner];
            e.grant  = NP'(1) << m_owner;
            e.locked = 1'b1;
            if (e.valid && bus.out_ready_i) e.shift = e.grant;
            e.tmo    = TMO_EN && (m_cnt == TMO);
        end
        return e;
    endfunction

    task automatic drive();
        logic [NP-1:0]    rq;
        logic [NP*FW-1:0] fl;
        for (int i = 0; i < NP; i++) begin
            rq[i] = (pq[i].size() > 0) && (!gap_en || ($urandom_range(3) != 0));
            fl[i*FW +: FW] = (pq[i].size() > 0) ? pq[i][0] : FW'($urandom);
        end
        bus.req_i      = rq;
        bus.req_flit_i = fl;
        bus.out_ready_i = (rdy_mode == 2) ? ($urandom_range(3) != 0) : (rdy_mode == 1);
    endtask

    // Model step at each edge, then present the next cycle's inputs.
    always @(posedge clk) begin
        exp_t e;
        int   o;
        int   p;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
        end else begin
            e = model_out();
            for (int i = 0; i < NP; i++)
                if (e.shift[i] && pq[i].size() > 0) void'(pq[i].pop_front());
            o = m_owner;
            if (o < 0) begin
                for (int k = 0; k < NP; k++) begin
                    p = (m_ptr + k) % NP;
                    if (m_owner < 0 && bus.req_i[p] &&
                        (ftype(bus.req_flit_i[p*FW +: FW]) == 1 || ftype(bus.req_flit_i[p*FW +: FW]) == 3)) begin
                        m_owner = p;
                        m_cnt   = 0;
                    end
                end
            end else if (e.tmo) begin
                m_owner = -1;
                m_ptr   = (o + 1) % NP;
                m_cnt   = 0;
            end else begin
                if (e.shift != '0) m_cnt = 0;
                else if (!e.valid) m_cnt++;
                if (e.shift != '0 && ftype(e.flit) >= 2) begin
                    m_owner = -1;
                    m_ptr   = (o + 1) % NP;
                end
            end
        end
        #1;
        drive();
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        exp_t e;
        e = model_out();
        check("shift_o",     32'(bus.shift_o),     32'(e.shift));
        check("out_flit_o",  32'(bus.out_flit_o),  32'(e.flit));
        check("out_valid_o", 32'(bus.out_valid_o), 32'(e.valid));
        check("grant_o",     32'(bus.grant_o),     32'(e.grant));
        check("locked_o",    32'(bus.locked_o),    32'(e.locked));
        check("timeout_o",   32'(bus.timeout_o),   32'(e.tmo));
        if (bus.out_valid_o && bus.out_ready_i) xfers++;
    end

    task automatic push(input int p, input logic [FW-1:0] f);
        pq[p].push_back(f);
        pushed++;
    endtask

    task automatic push_pkt(input int p, input int len);
        for (int i = 0; i < len; i++) begin
            logic [1:0] t;
            if (len == 1)           t = 2'b11;
            else if (i == 0)        t = 2'b01;
            else if (i == len - 1)  t = 2'b10;
            else                    t = 2'b00;
            push(p, {t, 14'($urandom)});
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit drained;
        drive();
        wait_neg(3);
        check("rst_grant",  32'(bus.grant_o), 32'h0);
        check("rst_locked", 32'(bus.locked_o), 32'h0);
        check("rst_valid",  32'(bus.out_valid_o), 32'h0);
        rst_n = 1'b1;

        // Lone SINGLE on port 0
        push(0, 16'hC0AA);
        wait_neg(1);
        check("single_c0_valid", 32'(bus.out_valid_o), 32'h0);
        wait_neg(1);
        check("single_c1_valid", 32'(bus.out_valid_o), 32'h1);
        check("single_c1_flit",  32'(bus.out_flit_o), 32'hC0AA);
        check("single_c1_shift", 32'(bus.shift_o), 32'h01);
        wait_neg(1);
        check("single_c2_locked", 32'(bus.locked_o), 32'h0);
        check("single_c2_ptr", 32'(m_ptr), 32'd1);

        // Port 4 packet brings the pointer back to 0
        push(4, 16'hC004);
        wait_neg(2);
        check("p4_grant", 32'(bus.grant_o), 32'h10);
        wait_neg(1);

        // Ports 0 and 2 contend with pointer 0
        push(0, 16'h4001); push(0, 16'h0002); push(0, 16'h8003);
        push(2, 16'h4200); push(2, 16'h8201);
        wait_neg(1);
        check("rr_c0_grant", 32'(bus.grant_o), 32'h0);
        wait_neg(1);
        check("rr_c1_grant", 32'(bus.grant_o), 32'h01);
        check("rr_c1_flit",  32'(bus.out_flit_o), 32'h4001);
        check("rr_c1_shift", 32'(bus.shift_o), 32'h01);
        wait_neg(1);
        check("rr_c2_flit",  32'(bus.out_flit_o), 32'h0002);
        check("rr_c2_p2shift", 32'(bus.shift_o[2]), 32'h0);
        wait_neg(1);
        check("rr_c3_flit",  32'(bus.out_flit_o), 32'h8003);
        check("rr_c3_p2shift", 32'(bus.shift_o[2]), 32'h0);
        wait_neg(1);
        check("rr_c4_locked", 32'(bus.locked_o), 32'h0);
        wait_neg(1);
        check("rr_c5_grant", 32'(bus.grant_o), 32'h04);
        check("rr_c5_flit",  32'(bus.out_flit_o), 32'h4200);
        wait_neg(1);
        check("rr_c6_flit",  32'(bus.out_flit_o), 32'h8201);
        wait_neg(1);

        // Owner 1 stalled by out_ready_i low for three cycles
        push(1, 16'h4011); push(1, 16'h0012); push(1, 16'h8013);
        wait_neg(2);
        check("stall_c1_flit", 32'(bus.out_flit_o), 32'h4011);
        rdy_mode = 0;
        for (int c = 0; c < 3; c++) begin
            wait_neg(1);
            check("stall_hold_valid", 32'(bus.out_valid_o), 32'h1);
            check("stall_hold_flit",  32'(bus.out_flit_o), 32'h0012);
            check("stall_hold_shift", 32'(bus.shift_o), 32'h0);
        end
        rdy_mode = 1;
        wait_neg(1);
        check("stall_resume_flit",  32'(bus.out_flit_o), 32'h0012);
        check("stall_resume_shift", 32'(bus.shift_o), 32'h02);
        wait_neg(1);
        check("stall_tail_flit", 32'(bus.out_flit_o), 32'h8013);
        wait_neg(1);

        // Stray BODY while idle never wins
        pq[3].push_back(16'h1234);
        for (int c = 0; c < 4; c++) begin
            wait_neg(1);
            check("body_grant",  32'(bus.grant_o), 32'h0);
            check("body_shift",  32'(bus.shift_o), 32'h0);
            check("body_locked", 32'(bus.locked_o), 32'h0);
        end
        pq[3].delete();
        wait_neg(1);

        // Owner 4 sends HEAD then goes silent
        push(4, 16'h4444);
        wait_neg(2);
        check("starve_head_shift", 32'(bus.shift_o), 32'h10);
        wait_neg(16);
        check("starve_c17_tmo", 32'(bus.timeout_o), 32'h0);
        wait_neg(1);
        check("starve_c18_tmo",    32'(bus.timeout_o), 32'(TMO_EN));
        check("starve_c18_locked", 32'(bus.locked_o), 32'h1);
        wait_neg(1);
        check("starve_c19_locked", 32'(bus.locked_o), 32'(!TMO_EN));
        check("starve_c19_tmo",    32'(bus.timeout_o), 32'h0);
        if (TMO_EN) check("starve_ptr", 32'(m_ptr), 32'd0);

        // Reset while a packet owns the output
        push(0, 16'h4050); push(0, 16'h0051);
        wait_neg(4);
        check("mid_locked", 32'(bus.locked_o), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_grant",  32'(bus.grant_o), 32'h0);
        check("arst_locked", 32'(bus.locked_o), 32'h0);
        check("arst_valid",  32'(bus.out_valid_o), 32'h0);
        check("arst_shift",  32'(bus.shift_o), 32'h0);
        check("arst_flit",   32'(bus.out_flit_o), 32'h0);
        check("arst_tmo",    32'(bus.timeout_o), 32'h0);
        for (int i = 0; i < NP; i++) pq[i].delete();
        wait_neg(1);
        rst_n = 1'b1;
        push(2, 16'h4200); push(2, 16'h8201);
        wait_neg(2);
        check("post_rst_grant", 32'(bus.grant_o), 32'h04);
        check("post_rst_flit",  32'(bus.out_flit_o), 32'h4200);
        wait_neg(2);

        // Randomized traffic with request gaps and ready stalls
        pushed = 0;
        xfers  = 0;
        gap_en = 1'b1;
        rdy_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            wait_neg(1);
            if ($urandom_range(3) == 0) begin
                int p;
                p = int'($urandom_range(NP - 1));
                if (pq[p].size() < 8) push_pkt(p, int'($urandom_range(4, 1)));
            end
        end
        gap_en = 1'b0;
        rdy_mode = 1;
        drained = 1'b0;
        for (int c = 0; c < 1000 && !drained; c++) begin
            wait_neg(1);
            drained = (m_owner < 0);
            for (int i = 0; i < NP; i++) if (pq[i].size() != 0) drained = 1'b0;
        end
        check("drain_done", 32'(drained), 32'h1);
        wait_neg(1);
        check("xfer_count", 32'(xfers), 32'(pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
